// File: rtl/wb_bus_arbiter_pkg.sv
// Shared types and helpers for the Wishbone shared-bus arbiter.
// Holds the arbiter state enum, the default watchdog limit and the owner-index width helper.
package wb_bus_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  function automatic int default_timeout();
    return 256;
  endfunction

  // An owner index is never narrower than one bit, even for two masters.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/wb_bus_arbiter_rr_priority_arbiter.sv
// Combinational one-hot round-robin pick: first request at or above the one-hot pointer,
// wrapping around. Shared with the NoC router allocators.
module rr_priority_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0] req,
  input  logic [N-1:0] ptr,
  output logic [N-1:0] grant
);

  logic [2*N-1:0] req_dbl;
  logic [2*N-1:0] gnt_dbl;

  // Doubling the request vector turns the wrap-around search into one subtraction.
  assign req_dbl = {req, req};
  assign gnt_dbl = req_dbl & ~(req_dbl - {{N{1'b0}}, ptr});
  assign grant   = gnt_dbl[N-1:0] | gnt_dbl[2*N-1:N];

endmodule

// File: rtl/wb_bus_arbiter.sv
// Round-robin Wishbone shared-bus arbiter; the owner keeps the bus while its cyc is high.
// Optional slave-response watchdog enabled by defining WB_ARB_TIMEOUT_EN.
module wb_bus_arbiter
  import wb_bus_pkg::*;
#(
  parameter int M       = 4,
  parameter int Mw      = clog2_min1(M),
  parameter int TIMEOUT = default_timeout()
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [M-1:0]  m_cyc_i,
  input  logic [M-1:0]  m_stb_i,
  input  logic          s_ack_i,
  input  logic          s_err_i,
  input  logic          s_rty_i,
  output logic [M-1:0]  grant_o,
  output logic [Mw-1:0] grant_id_o,
  output logic          bus_busy_o,
  output logic          timeout_err_o
);

  arb_state_e    state_reg;
  logic [M-1:0]  grant_reg;
  logic [M-1:0]  ptr_reg;
  logic [Mw-1:0] id_reg;
  logic          busy_reg;

  logic [M-1:0]  pick;
  logic [Mw-1:0] pick_id;
  logic          owner_cyc;
  logic          take_new;

  rr_priority_arbiter #(.N(M)) u_rr (
    .req   (m_cyc_i),
    .ptr   (ptr_reg),
    .grant (pick)
  );

  always_comb begin
    pick_id = '0;
    for (int i = 0; i < M; i++) begin
      if (pick[i]) pick_id = Mw'(i);
    end
  end

  assign owner_cyc = m_cyc_i[id_reg];
  // Arbitrate when idle or in the very cycle the owner lets go, so handover has no dead cycle.
  assign take_new  = (state_reg == IDLE) || !owner_cyc;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      grant_reg <= '0;
      id_reg    <= '0;
      busy_reg  <= 1'b0;
      ptr_reg   <= {{(M-1){1'b0}}, 1'b1};
    end else if (take_new) begin
      if (|m_cyc_i) begin
        state_reg <= BUSY;
        grant_reg <= pick;
        id_reg    <= pick_id;
        busy_reg  <= 1'b1;
        ptr_reg   <= {pick[M-2:0], pick[M-1]};
      end else begin
        state_reg <= IDLE;
        grant_reg <= '0;
        busy_reg  <= 1'b0;
      end
    end
  end

  assign grant_o    = grant_reg;
  assign grant_id_o = id_reg;
  assign bus_busy_o = busy_reg;

`ifdef WB_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] wd_cnt_reg;
  logic          timeout_reg;
  logic          owner_stb;
  logic          slave_resp;

  assign owner_stb  = m_stb_i[id_reg];
  assign slave_resp = s_ack_i | s_err_i | s_rty_i;

  // Any response, owner change or idle stb restarts the count; a response on the limit cycle wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      wd_cnt_reg  <= '0;
      timeout_reg <= 1'b0;
    end else begin
      timeout_reg <= 1'b0;
      if (state_reg == BUSY && !take_new && owner_stb && !slave_resp) begin
        if (wd_cnt_reg == CW'(TIMEOUT - 1)) begin
          timeout_reg <= 1'b1;
          wd_cnt_reg  <= '0;
        end else if (wd_cnt_reg != CW'(TIMEOUT)) begin
          wd_cnt_reg  <= wd_cnt_reg + 1'b1;
        end
      end else begin
        wd_cnt_reg <= '0;
      end
    end
  end

  assign timeout_err_o = timeout_reg;
`else
  localparam int unused_timeout = TIMEOUT;
  logic unused_wd_inputs;
  assign unused_wd_inputs = ^{m_stb_i, s_ack_i, s_err_i, s_rty_i};
  assign timeout_err_o    = 1'b0;
`endif

endmodule
